// File: rtl/com_stream_endpoint.sv
// com_stream_endpoint: host load stream into data memory, core release, result stream back to host.
// Optional COM_LOAD_CHECKSUM_EN adds load_checksum and a trailing checksum word on unload.
module com_stream_endpoint #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int OUT_BASE = 0,
  parameter int OUT_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] com_data_in,
  input  logic              data_write_start,
  input  logic              data_write_done,
  input  logic              core_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              core_start,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] com_data_out,
  output logic              output_write_start,
  output logic              output_write_done,
`ifdef COM_LOAD_CHECKSUM_EN
  output logic [DATA_W-1:0] load_checksum,
`endif
  output logic              load_overflow
);
  localparam logic [1:0] LOAD = 2'b00, RUN = 2'b01, UNLOAD = 2'b10, FINISH = 2'b11;
`ifdef COM_LOAD_CHECKSUM_EN
  localparam int LAST = OUT_LEN;
`else
  localparam int LAST = OUT_LEN - 1;
`endif
  logic [ADDR_W-1:0] load_addr;
  logic              load_full;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] held, word;
  logic              cap;
  assign cap = data_write_start | data_write_done;
`ifdef COM_LOAD_CHECKSUM_EN
  assign word = cnt == (ADDR_W+1)'(OUT_LEN) ? load_checksum : mem_rdata;
`else
  assign word = mem_rdata;
`endif
  // live read data while streaming, otherwise the last presented word
  assign com_data_out = (state == UNLOAD && output_write_start) ? word : held;
  assign output_write_done = state == FINISH ||
                             (state == UNLOAD && output_write_start && cnt == (ADDR_W+1)'(LAST));
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= LOAD;
      load_addr          <= '0;
      load_full          <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      mem_we             <= 1'b0;
      core_start         <= 1'b0;
      output_write_start <= 1'b0;
      load_overflow      <= 1'b0;
      cnt                <= '0;
      held               <= '0;
`ifdef COM_LOAD_CHECKSUM_EN
      load_checksum      <= '0;
`endif
    end else begin
      mem_we     <= 1'b0;
      core_start <= 1'b0;
      case (state)
        LOAD: if (cap) begin
          if (!load_full) begin
            mem_addr  <= load_addr;
            mem_wdata <= com_data_in;
            mem_we    <= 1'b1;
            load_addr <= load_addr + 1'b1;
            load_full <= &load_addr;
`ifdef COM_LOAD_CHECKSUM_EN
            load_checksum <= load_checksum + com_data_in;
`endif
          end else
            load_overflow <= 1'b1;
          if (data_write_done) begin
            state      <= RUN;
            core_start <= 1'b1;
          end
        end
        RUN: if (!core_start && core_done) begin
          state    <= UNLOAD;
          mem_addr <= ADDR_W'(OUT_BASE);
        end
        UNLOAD: begin
          mem_addr           <= mem_addr + 1'b1;
          output_write_start <= 1'b1;
          if (output_write_start) begin
            held <= com_data_out;
            cnt  <= cnt + 1'b1;
            if (output_write_done) state <= FINISH;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_com_stream_endpoint.sv
// tb_com_stream_endpoint: directed table plus corner sequences for com_stream_endpoint.
module tb_com_stream_endpoint;
  localparam int AW = 3;
  logic clk = 0, reset = 1, s = 0, d = 0, cd = 0;
  logic [15:0] din = 0, mem_rdata, mem_wdata, out;
  logic [AW-1:0] mem_addr;
  logic we, cst, ows, owd, ovf;
  logic [1:0] st;
`ifdef COM_LOAD_CHECKSUM_EN
  logic [15:0] cs;
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic [15:0] mem [8];
  int n = 0, fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  com_stream_endpoint #(.DATA_W(16), .ADDR_W(AW), .OUT_BASE(2), .OUT_LEN(3)) dut (
    .clk(clk), .reset(reset), .com_data_in(din), .data_write_start(s),
    .data_write_done(d), .core_done(cd), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(we), .core_start(cst), .state(st),
    .com_data_out(out), .output_write_start(ows), .output_write_done(owd),
`ifdef COM_LOAD_CHECKSUM_EN
    .load_checksum(cs),
`endif
    .load_overflow(ovf)
  );

  typedef struct {
    logic s, d, cd;
    logic [15:0] din;
    logic [1:0] st;
    logic we, cst;
    logic [2:0] a;
    logic [15:0] wd;
    logic ows, owd;
    logic [15:0] out;
  } row_t;
  row_t tv[13];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  task automatic step(input logic s_, input logic d_, input logic cd_, input logic [15:0] din_);
    s = s_; d = d_; cd = cd_; din = din_;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1,0,0,16'd10, 2'd0,1,0,3'd0,16'd10,0,0,16'd0};
    tv[1]  = '{1,0,0,16'd20, 2'd0,1,0,3'd1,16'd20,0,0,16'd0};
    tv[2]  = '{0,0,0,16'd99, 2'd0,0,0,3'd1,16'd20,0,0,16'd0};
    tv[3]  = '{1,0,0,16'd7,  2'd0,1,0,3'd2,16'd7, 0,0,16'd0};
    tv[4]  = '{1,0,0,16'd8,  2'd0,1,0,3'd3,16'd8, 0,0,16'd0};
    tv[5]  = '{0,1,0,16'd9,  2'd1,1,1,3'd4,16'd9, 0,0,16'd0};
    tv[6]  = '{0,0,1,16'd0,  2'd1,0,0,3'd4,16'd9, 0,0,16'd0};
    tv[7]  = '{0,0,1,16'd0,  2'd2,0,0,3'd2,16'd9, 0,0,16'd0};
    tv[8]  = '{0,0,0,16'd0,  2'd2,0,0,3'd3,16'd9, 1,0,16'd7};
    tv[9]  = '{0,0,0,16'd0,  2'd2,0,0,3'd4,16'd9, 1,0,16'd8};
    tv[10] = '{0,0,0,16'd0,  2'd2,0,0,3'd5,16'd9, 1,!CS,16'd9};
    if (CS) begin
      tv[11] = '{0,0,0,16'd0, 2'd2,0,0,3'd6,16'd9, 1,1,16'd54};
      tv[12] = '{0,0,0,16'd0, 2'd3,0,0,3'd7,16'd9, 1,1,16'd54};
    end else begin
      tv[11] = '{0,0,0,16'd0, 2'd3,0,0,3'd6,16'd9, 1,1,16'd9};
      tv[12] = '{0,0,0,16'd0, 2'd3,0,0,3'd6,16'd9, 1,1,16'd9};
    end

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset = 0;
    chk("rst_state", 0, 32'(st), 0);
    chk("rst_we", 0, 32'(we), 0);
    chk("rst_core_start", 0, 32'(cst), 0);
    chk("rst_ows", 0, 32'(ows), 0);
    chk("rst_owd", 0, 32'(owd), 0);
    chk("rst_out", 0, 32'(out), 0);
    chk("rst_ovf", 0, 32'(ovf), 0);

    for (int i = 0; i < 13; i++) begin
      step(tv[i].s, tv[i].d, tv[i].cd, tv[i].din);
      chk("state", i, 32'(st), 32'(tv[i].st));
      chk("mem_we", i, 32'(we), 32'(tv[i].we));
      chk("core_start", i, 32'(cst), 32'(tv[i].cst));
      chk("mem_addr", i, 32'(mem_addr), 32'(tv[i].a));
      chk("mem_wdata", i, 32'(mem_wdata), 32'(tv[i].wd));
      chk("ows", i, 32'(ows), 32'(tv[i].ows));
      chk("owd", i, 32'(owd), 32'(tv[i].owd));
      chk("out", i, 32'(out), 32'(tv[i].out));
    end
    chk("no_ovf", 0, 32'(ovf), 0);
`ifdef COM_LOAD_CHECKSUM_EN
    chk("cs_table", 0, 32'(cs), 54);
`endif

    // reset in the middle of unload, after one word
    reset = 1;
    step(0, 0, 0, 0);
    reset = 0;
    step(0, 1, 0, 16'd55);
    chk("done_only_state", 0, 32'(st), 1);
    chk("done_only_we", 0, 32'(we), 1);
    chk("done_only_addr", 0, 32'(mem_addr), 0);
    chk("done_only_wdata", 0, 32'(mem_wdata), 55);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("a_unload", 0, 32'(st), 2);
    step(0, 0, 0, 0);
    chk("a_word0", 0, 32'(out), 7);
    chk("a_ows", 0, 32'(ows), 1);
    reset = 1;
    step(0, 0, 0, 0);
    reset = 0;
    chk("abort_state", 0, 32'(st), 0);
    chk("abort_ows", 0, 32'(ows), 0);
    chk("abort_owd", 0, 32'(owd), 0);
    step(1, 0, 0, 16'd77);
    chk("reload_addr", 0, 32'(mem_addr), 0);
    chk("reload_we", 0, 32'(we), 1);

    // overflow: 10 words into an 8-word memory
    reset = 1;
    step(0, 0, 0, 0);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, i == 9, 0, 16'(100 + i));
      chk("ovf_we", i, 32'(we), 32'(i < 8));
      if (i < 8) chk("ovf_addr", i, 32'(mem_addr), 32'(i));
      chk("ovf_flag", i, 32'(ovf), 32'(i >= 8));
    end
    chk("ovf_run", 0, 32'(st), 1);
    step(0, 0, 0, 0);
    chk("ovf_sticky", 0, 32'(ovf), 1);
    for (int i = 0; i < 8; i++) chk("ovf_mem", i, 32'(mem[i]), 32'(100 + i));

`ifdef COM_LOAD_CHECKSUM_EN
    reset = 1;
    step(0, 0, 0, 0);
    reset = 0;
    chk("cs_rst", 0, 32'(cs), 0);
    step(1, 0, 0, 16'hFFFF);
    step(0, 1, 0, 16'h0002);
    chk("cs_sum", 0, 32'(cs), 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("cs_owd_early", 0, 32'(owd), 0);
    step(0, 0, 0, 0);
    chk("cs_word", 0, 32'(out), 1);
    chk("cs_owd", 0, 32'(owd), 1);
    step(0, 0, 0, 0);
    chk("cs_finish", 0, 32'(st), 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
